// File: rtl/barrel_shift_arbiter.sv
// barrel_shift_arbiter: round-robin front end for a shared pipelined shifter.
// Grants one requester per cycle, tags results and returns them in order.
`timescale 1ns/1ps
module barrel_shift_arbiter #(
  parameter int M   = 4,
  parameter int R   = 4,
  parameter int LAT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [R-1:0]             req_valid,
  input  logic [R*(8<<M)-1:0]      req_data,
  input  logic [R*M-1:0]           req_shift,
  output logic [R-1:0]             req_ready,
  input  logic                     flush,
  output logic                     flush_done,
  output logic [(8<<M)-1:0]        sh_a_in,
  output logic [M-1:0]             sh_shift,
  output logic                     sh_en_in,
  input  logic [(8<<M)-1:0]        sh_out,
  input  logic                     sh_en_out,
  output logic                     rsp_valid,
  output logic [$clog2(R)-1:0]     rsp_id,
  output logic [(8<<M)-1:0]        rsp_data,
  output logic                     busy,
  output logic                     err_orphan
);

  localparam int DW    = 8 << M;
  localparam int W     = $clog2(R);
  localparam int DEPTH = LAT + 2;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state_q;
  logic            flush_done_q;
  logic [W-1:0]    ptr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    tags_q [DEPTH];
  logic [PW-1:0]   wr_q, rd_q;
  logic [DW-1:0]   sh_a_q;
  logic [M-1:0]    sh_shift_q;
  logic            sh_en_q;
  logic            rsp_valid_q;
  logic [W-1:0]    rsp_id_q;
  logic [DW-1:0]   rsp_data_q;
  logic            err_q;

  logic            elig, gnt, pop, orphan;
  logic [W-1:0]    gidx;
  int              sidx;

  // Rotating-priority search from ptr for the first valid requester.
  always_comb begin
    elig = reset
      && (state_q == S_IDLE || state_q == S_RUN)
      && (cnt_q < CW'(DEPTH));
    gnt  = 1'b0;
    gidx = '0;
    sidx = 0;
    for (int k = 0; k < R; k++) begin
      sidx = (int'(ptr_q) + k) % R;
      if (elig && !gnt && req_valid[sidx]) begin
        gnt  = 1'b1;
        gidx = W'(sidx);
      end
    end
    req_ready = gnt ? (R'(1) << gidx) : '0;
  end

  assign pop    = sh_en_out && (cnt_q != '0);
  assign orphan = sh_en_out && (cnt_q == '0);

  // Outstanding-tag count: grant and pop together cancel out.
  always_comb begin
    cnt_d = cnt_q;
    if (gnt && !pop) cnt_d = cnt_q + CW'(1);
    else if (!gnt && pop) cnt_d = cnt_q - CW'(1);
  end

  // Datapath: shifter launch, tag FIFO and response register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q       <= '0;
      cnt_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      sh_a_q      <= '0;
      sh_shift_q  <= '0;
      sh_en_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tags_q[i] <= '0;
    end else begin
      sh_en_q     <= gnt;
      rsp_valid_q <= pop;
      cnt_q       <= cnt_d;
      if (gnt) begin
        sh_a_q       <= req_data[int'(gidx)*DW +: DW];
        sh_shift_q   <= req_shift[int'(gidx)*M +: M];
        ptr_q        <= (gidx == W'(R-1)) ? '0 : gidx + W'(1);
        tags_q[wr_q] <= gidx;
        wr_q         <= (wr_q == PW'(DEPTH-1)) ? '0 : wr_q + PW'(1);
      end
      if (pop) begin
        rsp_data_q <= sh_out;
        rsp_id_q   <= tags_q[rd_q];
        rd_q       <= (rd_q == PW'(DEPTH-1)) ? '0 : rd_q + PW'(1);
      end
      if (orphan) err_q <= 1'b1;
    end
  end

  // Control FSM: run, drain on flush, one-cycle done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (flush) state_q <= S_DRAIN;
          else if (|req_valid) state_q <= S_RUN;
        end
        S_RUN: begin
          if (flush) state_q <= S_DRAIN;
          else if (cnt_q == '0 && !(|req_valid) && !sh_en_q)
            state_q <= S_IDLE;
        end
        S_DRAIN: begin
          if (cnt_q == '0 && !sh_en_q) begin
            state_q      <= S_DONE;
            flush_done_q <= 1'b1;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign flush_done = flush_done_q;
  assign sh_a_in    = sh_a_q;
  assign sh_shift   = sh_shift_q;
  assign sh_en_in   = sh_en_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign err_orphan = err_q;
  assign busy       = (state_q != S_IDLE) || (cnt_q != '0);

endmodule

// File: doc/barrel_shift_arbiter.md
BARREL_SHIFT_ARBITER -- requirements
Module: barrel_shift_arbiter

Interface
REQ-001 Parameter M, default 4: shift-select width; the datapath is N = 2**M bytes (8*N bits).
REQ-002 Parameter R, default 4: number of requesters, range 2..8; W = max(1, clog2(R)).
REQ-003 Parameter LAT, default 4: barrel-shifter latency in cycles, from sh_en_in sampled to sh_en_out; DEPTH = LAT+2.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  R  per-requester request valid.
REQ-007 req_data  input  R*8*N  requester r operand at [r*8*N +: 8*N].
REQ-008 req_shift  input  R*M  requester r shift amount at [r*M +: M].
REQ-009 req_ready  output  R  one-hot grant; a handshake occurs on req_valid[r] & req_ready[r].
REQ-010 flush  input  1  request to drain the shifter and stop granting.
REQ-011 flush_done  output  1  single-cycle drain-complete pulse.
REQ-012 sh_a_in / sh_shift / sh_en_in  output  8*N / M / 1  drive the shared shifter.
REQ-013 sh_out / sh_en_out  input  8*N / 1  shifter result and result-valid.
REQ-014 rsp_valid / rsp_id / rsp_data  output  1 / W / 8*N  returned result, tagged with its requester index.
REQ-015 busy  output  1  high when state is not IDLE or count != 0.
REQ-016 err_orphan  output  1  sticky flag: sh_en_out arrived with no tag outstanding.

Function
REQ-017 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-018 Grant-eligible only in IDLE or RUN, and only while count < DEPTH.
REQ-019 When eligible, grant the first requester with req_valid set, searching from ptr upward modulo R.
REQ-020 req_ready is combinational and one-hot; it is all-zero when nothing is eligible.
REQ-021 On a grant: ptr <= (g+1) mod R, push g into the tag FIFO (depth DEPTH), count += 1.
REQ-022 On a grant: sh_a_in <= req_data[g], sh_shift <= req_shift[g], sh_en_in <= 1 in the next cycle.
REQ-023 With no grant: sh_en_in <= 0; sh_a_in and sh_shift hold their values.
REQ-024 Requesters hold req_valid and operands stable until handshake; the arbiter does not latch ungranted requests.
REQ-025 On sh_en_out with count > 0: pop the tag, count -= 1.
REQ-026 The cycle after that pop: rsp_valid = 1, rsp_data = sh_out as sampled, rsp_id = popped tag.
REQ-027 rsp_valid is 0 in all other cycles.
REQ-028 Handshake in cycle t produces rsp_valid in cycle t+LAT+2.
REQ-029 Grant and pop in the same cycle: count is unchanged. A grant is allowed when count == DEPTH-1 even if a pop coincides.
REQ-030 On sh_en_out with count == 0: set err_orphan; no pop, no rsp_valid, count stays 0.
REQ-031 IDLE -> RUN on any req_valid.
REQ-032 RUN -> IDLE when count == 0, no req_valid, and sh_en_in == 0.
REQ-033 flush sampled in IDLE or RUN -> DRAIN; grants stop from the following cycle.
REQ-034 DRAIN -> DONE when count == 0 and sh_en_in == 0.
REQ-035 DONE: flush_done = 1 for exactly one cycle, then -> IDLE.
REQ-036 flush sampled in DRAIN or DONE is ignored.
REQ-037 flush with count == 0: DRAIN for one cycle, then DONE.
REQ-038 The final rsp_valid precedes flush_done by exactly one cycle.

Reset
REQ-039 reset low forces asynchronously: state IDLE, ptr 0, count 0, tag FIFO empty, all outputs 0 (including err_orphan).
REQ-040 In-flight results at reset are discarded; the shifter shares reset, so no post-reset orphans are expected.
REQ-041 Reset deassertion is synchronized to clk by the integrator; the first grant is possible in the first cycle after deassertion.

Verification (M=4, R=4, LAT=4, DEPTH=6)
REQ-042 Single request: r2, bytes 0x00..0x0F, shift 3.
- req_ready = 4'b0100 in the same cycle; sh_en_in = 1 next cycle.
- rsp_valid at t+6 with rsp_id = 2 and rsp_data equal to the reference-model rotation.
REQ-043 All four requesters continuously valid from reset: grants 0,1,2,3,0,1 on consecutive cycles; rsp_ids return in the same order.
REQ-044 Stubbed shifter never asserting sh_en_out: exactly six grants, then req_ready = 0.
- A single sh_en_out pulse then permits exactly one more grant.
REQ-045 flush asserted after 3 grants with 3 in flight: no further req_ready; 3 rsp_valid; flush_done one cycle after the last; state returns to IDLE.
REQ-046 reset pulled low with 3 in flight: outputs 0 and busy = 0 immediately; after release, a new r1 request returns rsp_id = 1 at t+6.
REQ-047 sh_en_out pulse with count == 0: err_orphan = 1 and held until reset; rsp_valid stays 0.
